// File: rtl/t09_lcd_pkg.sv
// Shared definitions for the LCD write path: state encoding, default strobe
// timing, the per-byte beat record and small helpers used by the bus logic.
package t09_lcd_pkg;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_WR_LO = 2'd1;
  localparam logic [1:0] ST_WR_HI = 2'd2;
  localparam logic [1:0] ST_HOLD  = 2'd3;

  localparam int DEF_WR_LOW_CYC  = 2;
  localparam int DEF_WR_HIGH_CYC = 2;
  localparam int CNT_W           = 4;

  typedef logic [CNT_W-1:0] cnt_t;

  typedef struct packed {
    logic [7:0] data;
    logic       dcx;
    logic       last;
  } lcd_beat_t;

  // Counter load for a phase lasting cyc cycles (counts down to zero).
  function automatic cnt_t cyc_load(input int unsigned cyc);
    return cnt_t'(cyc - 1);
  endfunction

  // Round-robin pick between two requesters; a tie goes to the one that did
  // not own the previous burst.
  function automatic logic rr_pick(input logic v0, input logic v1,
                                   input logic last_owner);
    if (v0 && v1) return ~last_owner;
    return v1;
  endfunction

endpackage

// File: rtl/t09_lcd_bus_arbiter_wr_strobe.sv
// Write-strobe timing: one start pulse launches a WR_LO/WR_HI sequence; done
// marks the final WR_HI cycle, where a new start chains the next byte.
module t09_wr_strobe_gen
  import t09_lcd_pkg::*;
#(
  parameter int WR_LOW_CYC  = DEF_WR_LOW_CYC,
  parameter int WR_HIGH_CYC = DEF_WR_HIGH_CYC
) (
  input  logic       clk,
  input  logic       nrst,
  input  logic       start,
  output logic [1:0] phase,
  output logic       wr,
  output logic       done
);

  localparam cnt_t LOW_LOAD  = cyc_load(WR_LOW_CYC);
  localparam cnt_t HIGH_LOAD = cyc_load(WR_HIGH_CYC);

  logic [1:0] phase_q;
  cnt_t       cnt_q;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of the others.
  always_ff @(posedge clk) begin
    if (!nrst) begin
      phase_q <= ST_IDLE;
      cnt_q   <= '0;
    end else begin
      case (phase_q)
        ST_WR_LO: begin
          if (cnt_q == '0) begin
            phase_q <= ST_WR_HI;
            cnt_q   <= HIGH_LOAD;
          end else begin
            cnt_q <= cnt_q - cnt_t'(1);
          end
        end
        ST_WR_HI: begin
          if (cnt_q != '0) begin
            cnt_q <= cnt_q - cnt_t'(1);
          end else if (start) begin
            phase_q <= ST_WR_LO;
            cnt_q   <= LOW_LOAD;
          end else begin
            phase_q <= ST_IDLE;
            cnt_q   <= '0;
          end
        end
        default: begin
          if (start) begin
            phase_q <= ST_WR_LO;
            cnt_q   <= LOW_LOAD;
          end else begin
            phase_q <= ST_IDLE;
            cnt_q   <= '0;
          end
        end
      endcase
    end
  end

  assign phase = phase_q;
  assign wr    = (phase_q != ST_WR_LO);
  assign done  = (phase_q == ST_WR_HI) && (cnt_q == '0);

endmodule

// File: rtl/t09_lcd_bus_arbiter.sv
// Two-requester LCD 8080-style write arbiter: round-robin burst ownership,
// HOLD while the owner pauses mid-burst, strobe timing in t09_wr_strobe_gen.
module t09_lcd_bus_arbiter
  import t09_lcd_pkg::*;
#(
  parameter int WR_LOW_CYC  = DEF_WR_LOW_CYC,
  parameter int WR_HIGH_CYC = DEF_WR_HIGH_CYC
) (
  input  logic       clk,
  input  logic       nrst,
  input  logic       req0_valid,
  input  logic [7:0] req0_byte,
  input  logic       req0_dcx,
  input  logic       req0_last,
  output logic       req0_ready,
  input  logic       req1_valid,
  input  logic [7:0] req1_byte,
  input  logic       req1_dcx,
  input  logic       req1_last,
  output logic       req1_ready,
  output logic       wr,
  output logic       dcx,
  output logic [7:0] D,
  output logic       csx,
  output logic       owner,
  output logic       busy
);

  logic [1:0] phase;
  logic [1:0] state;
  logic       strobe_done;
  logic       hold_q;
  logic       cur_last_q;
  logic       owner_q;
  logic       last_owner_q;
  logic [7:0] d_q;
  logic       dcx_q;

  logic       accept;
  logic       sel;
  logic       owner_valid;
  lcd_beat_t  beat;

  // HOLD is the only state the strobe generator does not know about.
  assign state       = hold_q ? ST_HOLD : phase;
  assign owner_valid = owner_q ? req1_valid : req0_valid;

  // NOTE: every signal written here gets a default first, so no path through
  // the case leaves it unassigned and no latch is inferred.
  always_comb begin
    accept = 1'b0;
    sel    = owner_q;
    case (state)
      ST_IDLE: begin
        sel    = rr_pick(req0_valid, req1_valid, last_owner_q);
        accept = req0_valid | req1_valid;
      end
      ST_WR_HI: accept = strobe_done & ~cur_last_q & owner_valid;
      ST_HOLD:  accept = owner_valid;
      default:  accept = 1'b0;
    endcase
    if (!nrst) accept = 1'b0;
  end

  assign beat = sel ? lcd_beat_t'{req1_byte, req1_dcx, req1_last}
                    : lcd_beat_t'{req0_byte, req0_dcx, req0_last};

  assign req0_ready = accept & ~sel;
  assign req1_ready = accept & sel;

  t09_wr_strobe_gen #(
    .WR_LOW_CYC (WR_LOW_CYC),
    .WR_HIGH_CYC(WR_HIGH_CYC)
  ) u_strobe (
    .clk  (clk),
    .nrst (nrst),
    .start(accept),
    .phase(phase),
    .wr   (wr),
    .done (strobe_done)
  );

  always_ff @(posedge clk) begin
    if (!nrst) begin
      hold_q       <= 1'b0;
      cur_last_q   <= 1'b0;
      owner_q      <= 1'b0;
      last_owner_q <= 1'b1;
      d_q          <= 8'h00;
      dcx_q        <= 1'b0;
    end else if (accept) begin
      d_q        <= beat.data;
      dcx_q      <= beat.dcx;
      cur_last_q <= beat.last;
      owner_q    <= sel;
      hold_q     <= 1'b0;
    end else if (strobe_done) begin
      // Burst end records the owner for the next tie; otherwise the owner
      // has stalled and keeps the bus selected.
      if (cur_last_q) last_owner_q <= owner_q;
      else            hold_q       <= 1'b1;
    end
  end

  assign csx   = (state == ST_IDLE);
  assign busy  = (state != ST_IDLE);
  assign D     = d_q;
  assign dcx   = dcx_q;
  assign owner = owner_q;

endmodule

// File: doc/t09_lcd_bus_arbiter.md
T09_LCD_BUS_ARBITER -- requirements
Module: t09_lcd_bus_arbiter

Interface
REQ-001 SHALL have parameter WR_LOW_CYC, default 2: cycles wr is held low per byte, range 1..15.
REQ-002 SHALL have parameter WR_HIGH_CYC, default 2: cycles wr is held high after its rising edge, range 1..15.
REQ-003 clk  in  1  sole clock; all state changes on its rising edge.
REQ-004 nrst  in  1  synchronous, active-low reset.
REQ-005 req0_valid  in  1  game-image requester (pixel updater path) has a byte.
REQ-006 req0_byte  in  8  byte to write.
REQ-007 req0_dcx  in  1  0 = command byte, 1 = data byte.
REQ-008 req0_last  in  1  byte is final of a burst.
REQ-009 req0_ready  out  1  byte accepted when valid and ready are both high.
REQ-010 req1_valid, req1_byte[8], req1_dcx, req1_last, req1_ready: same meaning, for the score/overlay requester.
REQ-011 wr  out  1  LCD write strobe; panel latches on rising edge.
REQ-012 dcx  out  1  LCD data/command select.
REQ-013 D  out  8  LCD data bus.
REQ-014 csx  out  1  LCD chip select, active low.
REQ-015 owner  out  1  index of the requester holding or last holding the bus.
REQ-016 busy  out  1  high whenever state is not IDLE.

Function
REQ-017 States SHALL be IDLE, WR_LO, WR_HI and HOLD.
REQ-018 IDLE: csx=1, wr=1; if any valid, the winner SHALL be picked, ready SHALL be asserted combinationally to the winner only, and the byte SHALL be accepted that cycle.
REQ-019 Arbitration SHALL be round-robin: if both are valid, pick the requester not equal to the last burst owner; after reset, requester 0 wins ties.
REQ-020 Accept: register byte to D and dcx, set owner, and go to WR_LO; csx and wr go low the next cycle.
REQ-021 WR_LO: wr=0 for exactly WR_LOW_CYC cycles, then go to WR_HI; D and dcx stay stable.
REQ-022 WR_HI: wr=1 for exactly WR_HIGH_CYC cycles; D and dcx stay stable through the whole state.
REQ-023 Last cycle of WR_HI, if the current byte was not last and the owner is valid: ready goes to the owner, the next byte is accepted, and the state returns to WR_LO (back-to-back period = WR_LOW_CYC+WR_HIGH_CYC).
REQ-024 Last cycle of WR_HI, if not last and the owner is not valid: go to HOLD; csx stays 0 and wr stays 1.
REQ-025 HOLD: the owner byte SHALL be accepted as soon as the owner is valid, then go to WR_LO; the non-owner SHALL never get ready.
REQ-026 After the last WR_HI cycle of a last byte: go to IDLE, csx=1 for at least one cycle, and record the owner for round-robin.
REQ-027 A non-owner SHALL never see ready high during a burst (no preemption, no interleaving).
REQ-028 Ready SHALL be high in at most one cycle per byte and only to one requester.
REQ-029 Counter SHALL be 4 bits, loaded with the cycle count minus 1 on state entry and decrement to 0.
REQ-030 Accept latency: the wr falling edge SHALL occur exactly 1 cycle after the accept cycle.

Reset
REQ-031 While nrst=0 at a clock edge: state=IDLE, wr=1, csx=1, dcx=0, D=0, owner=0, busy=0, counter=0, last-owner=1 (so requester 0 wins first).
REQ-032 Ready outputs SHALL be 0 while nrst=0.
REQ-033 Reset mid-burst SHALL abort immediately; no further wr edge is produced.

Structure
REQ-034 State encoding and default timing constants SHALL live in shared package t09_lcd_pkg, reused by the pixel updater.
REQ-035 The wr timing (counter plus WR_LO/WR_HI sequencing) SHALL be one sub-module, t09_wr_strobe_gen, with start/done handshake; arbitration and HOLD logic stay in the top.

Verification
REQ-036 Single byte: req0 sends 0x2A with dcx=0, last=1 and default params -> wr low cycles 1-2, high cycles 3-4, D=0x2A, csx back to 1 at cycle 5.
REQ-037 Back-to-back burst: req0 sends 0x2C, 0x11, 0x22, 0x33 (last on 0x33), always valid -> wr falling edges every 4 cycles, csx low continuously, req1 ready never high.
REQ-038 Contention: both valid from reset -> req0 burst first, then req1 burst; both valid again -> req0 wins again (alternation).
REQ-039 Gap: req1 drops valid for 5 cycles mid-burst -> HOLD with csx=0 and wr=1, req0 is not granted, the burst resumes on revalidation.
REQ-040 Reset in WR_LO -> next cycle wr=1, csx=1, busy=0; a subsequent single-byte transfer behaves as in REQ-036.
REQ-041 WR_LOW_CYC=1, WR_HIGH_CYC=3 -> wr low 1 cycle, high 3 cycles, per-byte period 4 cycles.
